csr_access_ctrl: RTL and testbench

- Sequences Zicsr read-modify-write accesses (CSRRW/CSRRS/CSRRC and immediate forms, already resolved to operand) against the machine-mode CSR set.
- Sits between the execute stage and CSR storage; owns the storage for MSCRATCH and the 64-bit MCYCLE counter, and returns constants for the information registers and MISA.
- Flags illegal accesses for the trap logic.
- Uses a valid/ready request and response handshake, with one access in flight at a time.

---
 rtl/csr_access_ctrl_pkg.sv | 34 +++
 rtl/csr_access_ctrl_if.sv | 26 ++
 rtl/csr_access_ctrl_mcycle_counter.sv | 23 ++
 rtl/csr_access_ctrl.sv | 136 +++++++++++++
 tb/tb_csr_access_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/csr_access_ctrl_pkg.sv
// Shared CSR definitions: machine-mode addresses, access opcodes, controller
// states and the read-only address-space test.
package csr_access_ctrl_pkg;

  localparam logic [11:0] CSR_MISA       = 12'h301;
  localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
  localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
  localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
  localparam logic [11:0] CSR_MARCHID    = 12'hF12;
  localparam logic [11:0] CSR_MIMPID     = 12'hF13;
  localparam logic [11:0] CSR_MHARTID    = 12'hF14;
  localparam logic [11:0] CSR_MCONFIGPTR = 12'hF15;

  typedef enum logic [1:0] {
    OP_INVALID = 2'b00,
    OP_RW      = 2'b01,
    OP_RS      = 2'b10,
    OP_RC      = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } ctrl_state_e;

  // The top two address bits equal to 2'b11 mark the read-only CSR space.
  function automatic logic is_ro_addr(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// Request/response handshake between the execute stage (master) and the
// CSR access controller (slave).
interface csr_access_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            req_wr_en;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_illegal;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_wr_en, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_wr_en, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );
endinterface

// File: rtl/csr_access_ctrl_mcycle_counter.sv
// 64-bit free-running cycle counter with independent write ports for each half.
module csr_mcycle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo_en,
  input  logic        wr_hi_en,
  input  logic [31:0] wr_data,
  output logic [63:0] count
);

  // A write to either half suppresses the increment for the whole counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 64'h0;
    end else if (wr_lo_en || wr_hi_en) begin
      if (wr_lo_en) count[31:0]  <= wr_data;
      if (wr_hi_en) count[63:32] <= wr_data;
    end else begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Zicsr read-modify-write sequencer for the machine-mode CSR set; owns
// MSCRATCH and MCYCLE and reports illegal accesses to the trap logic.
module csr_access_ctrl
  import csr_access_ctrl_pkg::*;
#(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] MVENDORID_VAL = 32'h0,
  parameter logic [XLEN-1:0] MARCHID_VAL   = 32'h0,
  parameter logic [XLEN-1:0] MIMPID_VAL    = 32'h0,
  parameter logic [XLEN-1:0] HART_ID       = 32'h0,
  parameter logic [XLEN-1:0] MISA_VAL      = 32'h4000_0100
) (
  input logic               clk,
  input logic               rst,
  csr_access_ctrl_if.slave  bus
);

  ctrl_state_e     state;
  csr_op_e         op_p0;
  logic [11:0]     addr_p0;
  logic [XLEN-1:0] wdata_p0;
  logic            wr_en_p0;
  logic [XLEN-1:0] rdata_q;
  logic            illegal_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic [XLEN-1:0] mscratch;
  logic [63:0]     mcycle;

  logic [XLEN-1:0] rd_val;
  logic            addr_hit;
  logic            illegal_now;
  logic [XLEN-1:0] new_val;
  logic            commit;
  logic            mc_wr_lo;
  logic            mc_wr_hi;

  always_comb begin
    rd_val   = '0;
    addr_hit = 1'b1;
    case (addr_p0)
      CSR_MVENDORID:  rd_val = MVENDORID_VAL;
      CSR_MARCHID:    rd_val = MARCHID_VAL;
      CSR_MIMPID:     rd_val = MIMPID_VAL;
      CSR_MHARTID:    rd_val = HART_ID;
      CSR_MCONFIGPTR: rd_val = '0;
      CSR_MISA:       rd_val = MISA_VAL;
      CSR_MSCRATCH:   rd_val = mscratch;
      CSR_MCYCLE:     rd_val = mcycle[31:0];
      CSR_MCYCLEH:    rd_val = mcycle[63:32];
      default:        addr_hit = 1'b0;
    endcase
  end

  assign illegal_now = (op_p0 == OP_INVALID) || !addr_hit ||
                       (wr_en_p0 && is_ro_addr(addr_p0));

  // RMW works from the value sampled in READ, not the live counter.
  always_comb begin
    new_val = rdata_q;
    case (op_p0)
      OP_RW:   new_val = wdata_p0;
      OP_RS:   new_val = rdata_q | wdata_p0;
      OP_RC:   new_val = rdata_q & ~wdata_p0;
      default: new_val = rdata_q;
    endcase
  end

  assign commit   = (state == ST_WRITE) && !illegal_q && wr_en_p0;
  assign mc_wr_lo = commit && (addr_p0 == CSR_MCYCLE);
  assign mc_wr_hi = commit && (addr_p0 == CSR_MCYCLEH);

  csr_mcycle_counter u_mcycle (
    .clk      (clk),
    .rst      (rst),
    .wr_lo_en (mc_wr_lo),
    .wr_hi_en (mc_wr_hi),
    .wr_data  (new_val),
    .count    (mcycle)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      illegal_q   <= 1'b0;
      op_p0       <= OP_INVALID;
      addr_p0     <= '0;
      wdata_p0    <= '0;
      wr_en_p0    <= 1'b0;
      mscratch    <= '0;
    end else begin
      case (state)
        // Stage p0: capture the request
        ST_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            op_p0       <= csr_op_e'(bus.req_op);
            addr_p0     <= bus.req_addr;
            wdata_p0    <= bus.req_wdata;
            wr_en_p0    <= bus.req_wr_en;
            req_ready_q <= 1'b0;
            state       <= ST_READ;
          end
        end
        // Stage p1: sample old value and legality
        ST_READ: begin
          rdata_q   <= illegal_now ? '0 : rd_val;
          illegal_q <= illegal_now;
          state     <= ST_WRITE;
        end
        // Stage p2: commit the new value
        ST_WRITE: begin
          if (commit && (addr_p0 == CSR_MSCRATCH)) mscratch <= new_val;
          rsp_valid_q <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_illegal = illegal_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl: vector table of CSR accesses plus
// hand-written reset, back-pressure and mid-access reset sequences.
module tb_csr_access_ctrl;

  localparam logic [31:0] VENDOR = 32'h0000_0612;
  localparam logic [31:0] ARCH   = 32'h0000_0023;
  localparam logic [31:0] IMP    = 32'h0000_0045;
  localparam logic [31:0] HART   = 32'h0000_0003;
  localparam logic [31:0] MISAV  = 32'h4000_0100;

  localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11, INV = 2'b00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_access_ctrl_if #(.XLEN(32)) bus ();

  csr_access_ctrl #(
    .XLEN(32), .MVENDORID_VAL(VENDOR), .MARCHID_VAL(ARCH),
    .MIMPID_VAL(IMP), .HART_ID(HART), .MISA_VAL(MISAV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference mcycle: counts every edge out of reset; pending half-writes
  // replace the increment on the edge they are applied.
  logic [63:0] mc;
  logic        ovr_lo, ovr_hi;
  logic [31:0] ovr_val;
  always @(posedge clk or posedge rst) begin
    if (rst) mc <= 64'h0;
    else if (ovr_lo || ovr_hi) begin
      if (ovr_lo) mc[31:0]  <= ovr_val;
      if (ovr_hi) mc[63:32] <= ovr_val;
    end else mc <= mc + 64'd1;
  end

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        wr;
    logic [31:0] rd;
    logic        ill;
    logic        mc;
  } vec_t;

  localparam int NV = 26;
  vec_t v[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rmw(input logic [1:0] op, input logic [31:0] old,
                                      input logic [31:0] wd);
    case (op)
      RW:      return wd;
      RS:      return old | wd;
      RC:      return old & ~wd;
      default: return old;
    endcase
  endfunction

  // One full access with rsp_ready high; lat = handshake edge minus accept edge.
  task automatic access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                        input logic wr, input logic commit_exp,
                        output logic [31:0] rdata, output logic ill,
                        output logic [31:0] old_m, output int lat);
    int n;
    bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd; bus.req_wr_en = wr;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    old_m = (addr == 12'hB80) ? mc[63:32] : mc[31:0];
    @(posedge clk); #1;
    if (commit_exp && addr == 12'hB00) begin ovr_lo = 1'b1; ovr_val = rmw(op, old_m, wd); end
    if (commit_exp && addr == 12'hB80) begin ovr_hi = 1'b1; ovr_val = rmw(op, old_m, wd); end
    @(posedge clk); #1;
    ovr_lo = 1'b0; ovr_hi = 1'b0;
    n = 2;
    while (!bus.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    rdata = bus.rsp_rdata;
    ill   = bus.rsp_illegal;
    @(posedge clk); #1;
    lat = n + 1;
  endtask

  logic [31:0] rd, old;
  logic        ill;
  int          lat, n;

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wr_en = 1'b0; bus.rsp_ready = 1'b1;
    ovr_lo = 1'b0; ovr_hi = 1'b0; ovr_val = '0;

    v[0]  = '{RW,  12'h340, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    v[1]  = '{RS,  12'h340, 32'h0000_00F0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
    v[2]  = '{RC,  12'h340, 32'h0000_000F, 1'b1, 32'hDEAD_BEFF, 1'b0, 1'b0};
    v[3]  = '{RS,  12'h340, 32'h0000_0000, 1'b0, 32'hDEAD_BEF0, 1'b0, 1'b0};
    v[4]  = '{RW,  12'hF11, 32'h0000_1234, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    v[5]  = '{RS,  12'hF11, 32'h0000_0000, 1'b0, VENDOR,        1'b0, 1'b0};
    v[6]  = '{RW,  12'h7B0, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    v[7]  = '{INV, 12'h340, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    v[8]  = '{RS,  12'h340, 32'h0000_0000, 1'b0, 32'hDEAD_BEF0, 1'b0, 1'b0};
    v[9]  = '{RS,  12'h301, 32'h0000_0000, 1'b0, MISAV,         1'b0, 1'b0};
    v[10] = '{RW,  12'h301, 32'h0000_0000, 1'b1, MISAV,         1'b0, 1'b0};
    v[11] = '{RS,  12'h301, 32'h0000_0000, 1'b0, MISAV,         1'b0, 1'b0};
    v[12] = '{RS,  12'hF14, 32'h0000_0000, 1'b0, HART,          1'b0, 1'b0};
    v[13] = '{RS,  12'hF12, 32'h0000_0000, 1'b0, ARCH,          1'b0, 1'b0};
    v[14] = '{RS,  12'hF13, 32'h0000_0000, 1'b0, IMP,           1'b0, 1'b0};
    v[15] = '{RS,  12'hF15, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    v[16] = '{RS,  12'hF15, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    v[17] = '{RW,  12'hB80, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    v[18] = '{RW,  12'hB00, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    v[19] = '{RS,  12'hB80, 32'h0000_0000, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
    v[20] = '{RS,  12'hB00, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    v[21] = '{RW,  12'hB80, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    v[22] = '{RW,  12'hB00, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    v[23] = '{RS,  12'hB80, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    v[24] = '{RC,  12'hB00, 32'h0000_00F0, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    v[25] = '{RS,  12'hB00, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready",   {31'b0, bus.req_ready},   32'd1);
    check("reset_rsp_valid",   {31'b0, bus.rsp_valid},   32'd0);
    check("reset_rsp_rdata",   bus.rsp_rdata,            32'd0);
    check("reset_rsp_illegal", {31'b0, bus.rsp_illegal}, 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // First MCYCLE read after reset
    access(RS, 12'hB00, 32'h0, 1'b0, 1'b0, rd, ill, old, lat);
    check("mcycle_first_rdata",   rd,             old);
    check("mcycle_first_illegal", {31'b0, ill},   32'd0);
    check("mcycle_first_latency", lat,            32'd3);
    check("rsp_valid_drops",      {31'b0, bus.rsp_valid}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      access(v[i].op, v[i].addr, v[i].wd, v[i].wr, v[i].wr && !v[i].ill, rd, ill, old, lat);
      check($sformatf("vec%0d_rdata", i),   rd,           v[i].mc ? old : v[i].rd);
      check($sformatf("vec%0d_illegal", i), {31'b0, ill}, {31'b0, v[i].ill});
      check($sformatf("vec%0d_latency", i), lat,          32'd3);
    end

    // Back-pressure: response held while a competing request waits
    bus.rsp_ready = 1'b0;
    bus.req_op = RS; bus.req_addr = 12'h340; bus.req_wdata = '0; bus.req_wr_en = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_op = RW; bus.req_wdata = 32'h5555_5555; bus.req_wr_en = 1'b1;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp_valid_seen", {31'b0, bus.rsp_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_rsp_valid", k), {31'b0, bus.rsp_valid}, 32'd1);
      check($sformatf("bp%0d_rsp_rdata", k), bus.rsp_rdata,           32'hDEAD_BEF0);
      check($sformatf("bp%0d_req_ready", k), {31'b0, bus.req_ready}, 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rsp_valid_cleared", {31'b0, bus.rsp_valid}, 32'd0);
    access(RS, 12'h340, 32'h0, 1'b0, 1'b0, rd, ill, old, lat);
    check("bp_mscratch_kept", rd, 32'hDEAD_BEF0);

    // Reset asserted while an MSCRATCH write is in its WRITE cycle
    bus.req_op = RW; bus.req_addr = 12'h340; bus.req_wdata = 32'h1111_2222;
    bus.req_wr_en = 1'b1; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("midrst_rsp_rdata", bus.rsp_rdata,           32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    access(RS, 12'h340, 32'h0, 1'b0, 1'b0, rd, ill, old, lat);
    check("midrst_mscratch", rd, 32'h0);
    check("midrst_latency",  lat, 32'd3);
    access(RS, 12'hB00, 32'h0, 1'b0, 1'b0, rd, ill, old, lat);
    check("midrst_mcycle",   rd, old);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
